booth_div: RTL and testbench

- Sequential signed divider; the inverse of the team's 8x8 Booth multiplier.
- Divides a 16-bit signed dividend (the multiplier's product width) by an 8-bit signed divisor.
- Returns an 8-bit signed quotient and an 8-bit signed remainder, plus overflow and divide-by-zero flags.
- Uses the same load/result style as the multiplier so benches and datapaths can round-trip products.

---
 rtl/booth_div_pkg.sv | 23 ++
 rtl/booth_div_if.sv | 29 ++
 rtl/booth_div_step.sv | 28 ++
 rtl/booth_div.sv | 160 ++++++++++++++++
 tb/tb_booth_div.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/booth_div_pkg.sv
// ---------------------------------------------------------------------------
// booth_div_pkg
// Shared widths, FSM state encoding and saturation constants for the
// sequential signed divider (booth_div).
// Optional feature macro used by the divider: BOOTH_DIV_EARLY_EXIT_EN.
// ---------------------------------------------------------------------------
package booth_div_pkg;

    localparam int DIV_DW  = 8;          // divisor / quotient / remainder width
    localparam int DIV_DDW = 2 * DIV_DW; // dividend width (multiplier product width)
    localparam int DIV_CW  = 5;          // iteration counter width, 2^CW > 2*DW

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic signed [DIV_DW-1:0] QMAX = 8'sh7F;
    localparam logic signed [DIV_DW-1:0] QMIN = 8'sh80;

endpackage

// File: rtl/booth_div_if.sv
// ---------------------------------------------------------------------------
// booth_div_if
// Load/result bus of the signed divider.
//   master : drives load, dividend, divisor; observes results and flags
//   slave  : the divider side
// ---------------------------------------------------------------------------
interface booth_div_if #(
    parameter int DW = 8
);
    logic                   load;
    logic signed [2*DW-1:0] dividend;
    logic signed [DW-1:0]   divisor;
    logic signed [DW-1:0]   quotient;
    logic signed [DW-1:0]   remainder;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic                   div_zero;

    modport master (
        output load, dividend, divisor,
        input  quotient, remainder, busy, done, overflow, div_zero
    );

    modport slave (
        input  load, dividend, divisor,
        output quotient, remainder, busy, done, overflow, div_zero
    );
endinterface

// File: rtl/booth_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on unsigned magnitudes.
//   prem_i : partial remainder (always < dmag_i, so DW bits suffice)
//   qmag_i : dividend/quotient shift register
//   dmag_i : divisor magnitude (DW+1 bits, up to 2^(DW-1))
//   prem_o : next partial remainder
//   qmag_o : next shift register, new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0]   prem_i,
    input  logic [2*DW-1:0] qmag_i,
    input  logic [DW:0]     dmag_i,
    output logic [DW-1:0]   prem_o,
    output logic [2*DW-1:0] qmag_o
);
    logic [DW:0] shifted;
    logic        ge;

    assign shifted = {prem_i, qmag_i[2*DW-1]};
    assign ge      = (shifted >= dmag_i);

    // Difference is below dmag_i whenever ge holds, so the top bit is always 0.
    assign prem_o = ge ? DW'(shifted - dmag_i) : shifted[DW-1:0];
    assign qmag_o = {qmag_i[2*DW-2:0], ge};
endmodule

// File: rtl/booth_div.sv
// ---------------------------------------------------------------------------
// booth_div
// Sequential signed divider: 2*DW-bit dividend / DW-bit divisor giving a
// truncating DW-bit quotient and remainder, with overflow and div-by-zero.
// One restoring iteration per clock in RUN, sign/saturation fix-up in FIX.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : booth_div_if.slave (load, dividend, divisor, quotient,
//           remainder, busy, done, overflow, div_zero)
// Optional macro BOOTH_DIV_EARLY_EXIT_EN: a zero dividend or divisor skips
// RUN and finishes one cycle after load; results are unchanged.
//
// state | meaning
// IDLE  | waiting for load, outputs at reset values
// RUN   | one restoring iteration per cycle, 2*DW cycles
// FIX   | apply signs, detect overflow / divide by zero
// DONE  | results valid and held until the next load
// ---------------------------------------------------------------------------
module booth_div
    import booth_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int CW = DIV_CW
) (
    input  logic clk,
    input  logic reset,
    booth_div_if.slave bus
);
    localparam logic [CW-1:0]   LAST_CNT = CW'(2*DW-1);
    localparam logic [2*DW-1:0] QLIM_P   = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW-1:0] QLIM_N   = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]   SAT_P    = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   SAT_N    = {1'b1, {(DW-1){1'b0}}};

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         prem_q, prem_d;
    logic [2*DW-1:0]       qmag_q, qmag_d;
    logic [DW:0]           dmag_q, dmag_d;
    logic                  sn_q, sn_d, sd_q, sd_d;
    logic signed [DW-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic                  ovf_q, ovf_d, dz_q, dz_d;

    logic [DW-1:0]         prem_nx;
    logic [2*DW-1:0]       qmag_nx;
    logic [2*DW-1:0]       a_mag;
    logic signed [DW:0]    b_ext;
    logic [DW:0]           b_mag;
    logic                  q_neg;

    // -(-2^(2DW-1)) wraps to 2^(2DW-1), which is the correct unsigned magnitude.
    assign a_mag = bus.dividend[2*DW-1] ? -bus.dividend : bus.dividend;
    assign b_ext = {bus.divisor[DW-1], bus.divisor};
    assign b_mag = b_ext[DW] ? -b_ext : b_ext;
    assign q_neg = sn_q ^ sd_q;

    div_step #(.DW(DW)) u_step (
        .prem_i (prem_q),
        .qmag_i (qmag_q),
        .dmag_i (dmag_q),
        .prem_o (prem_nx),
        .qmag_o (qmag_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        qmag_d  = qmag_q;
        dmag_d  = dmag_q;
        sn_d    = sn_q;
        sd_d    = sd_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.load) begin
                    sn_d    = bus.dividend[2*DW-1];
                    sd_d    = bus.divisor[DW-1];
                    qmag_d  = a_mag;
                    dmag_d  = b_mag;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef BOOTH_DIV_EARLY_EXIT_EN
                    if ((bus.divisor == '0) || (bus.dividend == '0)) begin
                        qmag_d  = '0;
                        state_d = FIX;
                    end
`endif
                end
            end
            RUN: begin
                prem_d = prem_nx;
                qmag_d = qmag_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (dmag_q == '0) begin
                    dz_d   = 1'b1;
                    ovf_d  = 1'b0;
                    quot_d = '0;
                    rem_d  = '0;
                end else begin
                    dz_d  = 1'b0;
                    rem_d = sn_q ? -$signed(prem_q) : $signed(prem_q);
                    if ((!q_neg && (qmag_q > QLIM_P)) || (q_neg && (qmag_q > QLIM_N))) begin
                        ovf_d  = 1'b1;
                        quot_d = q_neg ? $signed(SAT_N) : $signed(SAT_P);
                    end else begin
                        ovf_d  = 1'b0;
                        quot_d = q_neg ? -$signed(qmag_q[DW-1:0]) : $signed(qmag_q[DW-1:0]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            qmag_q  <= '0;
            dmag_q  <= '0;
            sn_q    <= 1'b0;
            sd_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            qmag_q  <= qmag_d;
            dmag_q  <= dmag_d;
            sn_q    <= sn_d;
            sd_q    <= sd_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.overflow  = ovf_q;
    assign bus.div_zero  = dz_q;
    assign bus.busy      = (state_q == RUN) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_booth_div.sv
// ---------------------------------------------------------------------------
// tb_booth_div
// Self-checking bench for booth_div: vector table with a result scoreboard,
// plus hand-written control sequences (ignored load, reset abort, hold).
// ---------------------------------------------------------------------------
module tb_booth_div;
    import booth_div_pkg::*;

    typedef struct {
        logic signed [15:0] a;
        logic signed [7:0]  b;
        logic signed [7:0]  q;
        logic signed [7:0]  r;
        logic               ov;
        logic               dz;
        int                 start;
        int                 lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t vecs[14];

    booth_div_if #(.DW(8)) bif ();

    booth_div dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic signed [15:0] a, input logic signed [7:0] b,
                                input logic signed [7:0] q, input logic signed [7:0] r,
                                input logic ov, input logic dz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.ov = ov; e.dz = dz;
        e.start = 0;
`ifdef BOOTH_DIV_EARLY_EXIT_EN
        e.lat = ((a == 0) || (b == 0)) ? 1 : 17;
`else
        e.lat = 17;
`endif
        return e;
    endfunction

    task automatic start_op(input exp_t e);
        exp_t x;
        x = e;
        bif.load     = 1'b1;
        bif.dividend = e.a;
        bif.divisor  = e.b;
        @(posedge clk);
        #1;
        x.start = cyc;
        sb.push_back(x);
        bif.load     = 1'b0;
        bif.dividend = 16'($urandom);
        bif.divisor  = 8'($urandom);
        chk("busy_after_load", bif.busy, 1);
        chk("done_after_load", bif.done, 0);
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        e = sb[0];
        while (!bif.done && (cyc - e.start) < 60) begin
            @(posedge clk);
            #1;
        end
        void'(sb.pop_front());
        chk({tag, "_done_seen"}, bif.done, 1);
        if (bif.done) begin
            chk({tag, "_latency"}, cyc - e.start, e.lat);
            chk({tag, "_quotient"}, bif.quotient, e.q);
            chk({tag, "_remainder"}, bif.remainder, e.r);
            chk({tag, "_overflow"}, bif.overflow, e.ov);
            chk({tag, "_div_zero"}, bif.div_zero, e.dz);
            chk({tag, "_busy"}, bif.busy, 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_quotient"}, bif.quotient, 0);
        chk({tag, "_remainder"}, bif.remainder, 0);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_done"}, bif.done, 0);
        chk({tag, "_overflow"}, bif.overflow, 0);
        chk({tag, "_div_zero"}, bif.div_zero, 0);
    endtask

    initial begin
        logic signed [7:0] held_q;
        vecs[0]  = mk(16'sd425,    8'sd5,    8'sd85,   8'sd0,   1'b0, 1'b0);
        vecs[1]  = mk(-16'sd215,   8'sd5,   -8'sd43,   8'sd0,   1'b0, 1'b0);
        vecs[2]  = mk(16'sd100,   -8'sd7,   -8'sd14,   8'sd2,   1'b0, 1'b0);
        vecs[3]  = mk(-16'sd100,   8'sd7,   -8'sd14,  -8'sd2,   1'b0, 1'b0);
        vecs[4]  = mk(-16'sd100,  -8'sd7,    8'sd14,  -8'sd2,   1'b0, 1'b0);
        vecs[5]  = mk(16'sd16129,  8'sd127,  8'sd127,  8'sd0,   1'b0, 1'b0);
        vecs[6]  = mk(-16'sd16384, 8'sd127,  QMIN,    -8'sd1,   1'b1, 1'b0);
        vecs[7]  = mk(16'sd16256,  8'sd127,  QMAX,     8'sd0,   1'b1, 1'b0);
        vecs[8]  = mk(16'h8000,   -8'sd1,    QMAX,     8'sd0,   1'b1, 1'b0);
        vecs[9]  = mk(16'sd1234,   8'sd0,    8'sd0,    8'sd0,   1'b0, 1'b1);
        vecs[10] = mk(16'sd0,      8'sd5,    8'sd0,    8'sd0,   1'b0, 1'b0);
        vecs[11] = mk(16'sd1000,   8'h80,   -8'sd7,    8'sd104, 1'b0, 1'b0);
        vecs[12] = mk(16'sd32767,  8'h80,    QMIN,     8'sd127, 1'b1, 1'b0);
        vecs[13] = mk(-16'sd128,   8'sd1,   -8'sd128,  8'sd0,   1'b0, 1'b0);

        // Reset with load held high: reset must win.
        reset        = 1'b1;
        bif.load     = 1'b1;
        bif.dividend = 16'sd425;
        bif.divisor  = 8'sd5;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset    = 1'b0;
        bif.load = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", bif.busy, 0);

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i]);
            wait_result($sformatf("vec%0d", i));
        end

        // Results hold in DONE while load stays low.
        held_q = bif.quotient;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_done", bif.done, 1);
        chk("hold_quotient", bif.quotient, held_q);

        // A second load while busy is ignored.
        start_op(mk(16'sd425, 8'sd5, 8'sd85, 8'sd0, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        #1;
        bif.load     = 1'b1;
        bif.dividend = 16'sd1000;
        bif.divisor  = 8'sd3;
        @(posedge clk);
        #1;
        bif.load = 1'b0;
        wait_result("ignore_load");

        // Reset at E8 aborts an operation; load in the same cycle is dropped.
        start_op(mk(16'sd100, -8'sd7, -8'sd14, 8'sd2, 1'b0, 1'b0));
        void'(sb.pop_back());
        repeat (7) @(posedge clk);
        #1;
        chk("pre_abort_busy", bif.busy, 1);
        reset    = 1'b1;
        bif.load = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("abort");
        reset    = 1'b0;
        bif.load = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_idle_busy", bif.busy, 0);
        chk("abort_idle_done", bif.done, 0);

        start_op(mk(-16'sd100, 8'sd7, -8'sd14, -8'sd2, 1'b0, 1'b0));
        wait_result("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
